// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the MEM-stage data-memory controller.
// Holds the FUNC_* access codes used by decode, the controller state enum,
// and small helpers for access size, byte-lane enables and load extension.
package dmem_pkg;

    // Codes are {major opcode, funct3} so decode can pass them straight through
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [9:0] FUNC_LB  = {OPC_LOAD,  3'b000};
    localparam logic [9:0] FUNC_LH  = {OPC_LOAD,  3'b001};
    localparam logic [9:0] FUNC_LW  = {OPC_LOAD,  3'b010};
    localparam logic [9:0] FUNC_LBU = {OPC_LOAD,  3'b100};
    localparam logic [9:0] FUNC_LHU = {OPC_LOAD,  3'b101};
    localparam logic [9:0] FUNC_SB  = {OPC_STORE, 3'b000};
    localparam logic [9:0] FUNC_SH  = {OPC_STORE, 3'b001};
    localparam logic [9:0] FUNC_SW  = {OPC_STORE, 3'b010};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT2 = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    // Number of bytes touched by an access; 0 flags an unknown code
    function automatic logic [2:0] access_size(input logic [9:0] funct);
        case (funct)
            FUNC_LB, FUNC_LBU, FUNC_SB: access_size = 3'd1;
            FUNC_LH, FUNC_LHU, FUNC_SH: access_size = 3'd2;
            FUNC_LW, FUNC_SW:           access_size = 3'd4;
            default:                    access_size = 3'd0;
        endcase
    endfunction

    function automatic logic is_load_funct(input logic [9:0] funct);
        is_load_funct = (funct == FUNC_LB) || (funct == FUNC_LH) || (funct == FUNC_LW) ||
                        (funct == FUNC_LBU) || (funct == FUNC_LHU);
    endfunction

    function automatic logic is_store_funct(input logic [9:0] funct);
        is_store_funct = (funct == FUNC_SB) || (funct == FUNC_SH) || (funct == FUNC_SW);
    endfunction

    // Right-aligned lane mask for an access of the given size
    function automatic logic [3:0] size_mask(input logic [2:0] size);
        case (size)
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    // Lanes of the addressed word covered by the access
    function automatic logic [3:0] byte_enables_lo(input logic [2:0] size, input logic [1:0] lane);
        byte_enables_lo = size_mask(size) << lane;
    endfunction

    // Lanes of the following word covered by an access that spills over
    function automatic logic [3:0] byte_enables_hi(input logic [2:0] size, input logic [1:0] lane);
        byte_enables_hi = size_mask(size) >> (3'd4 - {1'b0, lane});
    endfunction

    // Sign/zero extension of a right-aligned raw load value
    function automatic logic [31:0] extend_load(input logic [9:0] funct, input logic [31:0] raw);
        case (funct)
            FUNC_LB:  extend_load = {{24{raw[7]}}, raw[7:0]};
            FUNC_LBU: extend_load = {24'd0, raw[7:0]};
            FUNC_LH:  extend_load = {{16{raw[15]}}, raw[15:0]};
            FUNC_LHU: extend_load = {16'd0, raw[15:0]};
            FUNC_LW:  extend_load = raw;
            default:  extend_load = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: single-port 32-bit SRAM with four byte-write lanes and a
// synchronous read. Contents are never reset.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane writes plus registered read of the addressed word (old data on a write)
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            rdata_o <= mem[idx_i];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-memory controller with valid/ready requests,
// registered read path and out-of-range error reporting.
// Build option DMEM_MISALIGN_EN: when defined, misaligned LH/LHU/LW/SH/SW are
// split into two beats; when undefined they return an error.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [9:0]  funct_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    state_e state;

    // request decode
    logic              accept;
    logic [2:0]        req_size;
    logic [1:0]        req_lane;
    logic [32:0]       req_off;
    logic [32:0]       req_end;
    logic              in_range;
    logic              funct_ok;
    logic              misaligned;
    logic              req_err;
    logic [IDX_W-1:0]  req_idx;
    logic [3:0]        be_lo;
    logic [31:0]       lo_wdata;

    // bank port
    logic              bank_en;
    logic [3:0]        bank_be;
    logic [IDX_W-1:0]  bank_idx;
    logic [31:0]       bank_wdata;
    logic [31:0]       bank_rdata;

    // registered access context and response
    logic              cur_err;
    logic              cur_we;
    logic [9:0]        cur_funct;
    logic [1:0]        cur_lane;
    logic [31:0]       resp_raw;
    logic [31:0]       resp_rdata;
    logic [31:0]       rdata_hold;
    logic              err_hold;

`ifdef DMEM_MISALIGN_EN
    logic              req_split;
    logic [3:0]        be_hi;
    logic [31:0]       hi_wdata;
    logic              cur_split;
    logic [IDX_W-1:0]  cur_idx;
    logic [3:0]        cur_be_hi;
    logic [31:0]       cur_wdata_hi;
    logic [31:0]       save_lo;
    logic [31:0]       resp_lo;
`endif

    assign accept = req_i && ready_o && rst_n_i;

    // Classify the incoming request: size, range, alignment and lane-shifted store data
    always_comb begin
        req_size   = access_size(funct_i);
        req_lane   = addr_i[1:0];
        req_off    = {1'b0, addr_i} - {1'b0, BASE_ADDR};
        req_end    = req_off + {30'd0, req_size};
        in_range   = (addr_i >= BASE_ADDR) && (req_end <= MEM_BYTES) && (req_size != 3'd0);
        funct_ok   = we_i ? is_store_funct(funct_i) : is_load_funct(funct_i);
        misaligned = 1'b0;
        if (req_size == 3'd4) begin
            misaligned = (req_lane != 2'd0);
        end else if (req_size == 3'd2) begin
            misaligned = req_lane[0];
        end
        req_idx  = req_off[IDX_W+1:2];
        be_lo    = byte_enables_lo(req_size, req_lane);
        lo_wdata = wdata_i << {req_lane, 3'b000};
`ifdef DMEM_MISALIGN_EN
        req_err   = !funct_ok || !in_range;
        req_split = misaligned && !req_err;
        be_hi     = byte_enables_hi(req_size, req_lane);
        case (req_lane)
            2'd1:    hi_wdata = {24'd0, wdata_i[31:24]};
            2'd2:    hi_wdata = {16'd0, wdata_i[31:16]};
            2'd3:    hi_wdata = {8'd0,  wdata_i[31:8]};
            default: hi_wdata = 32'd0;
        endcase
`else
        req_err = !funct_ok || !in_range || misaligned;
`endif
    end

    // Bank port: first beat from the accepted request, second beat from the saved context
    always_comb begin
        bank_en    = 1'b0;
        bank_be    = 4'd0;
        bank_idx   = req_idx;
        bank_wdata = lo_wdata;
        if (accept && !req_err) begin
            bank_en = 1'b1;
            bank_be = we_i ? be_lo : 4'd0;
        end
`ifdef DMEM_MISALIGN_EN
        if (state == ST_BEAT2) begin
            bank_en    = rst_n_i;
            bank_be    = cur_be_hi;
            bank_idx   = cur_idx + IDX_W'(1);
            bank_wdata = cur_wdata_hi;
        end
`endif
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk_i   (clk_i),
        .en_i    (bank_en),
        .be_i    (bank_be),
        .idx_i   (bank_idx),
        .wdata_i (bank_wdata),
        .rdata_o (bank_rdata)
    );

    // Response data: pick bytes by lane (joining both beats when split) and extend
    always_comb begin
`ifdef DMEM_MISALIGN_EN
        resp_lo = cur_split ? save_lo : bank_rdata;
        case (cur_lane)
            2'd1:    resp_raw = {bank_rdata[7:0],  resp_lo[31:8]};
            2'd2:    resp_raw = {bank_rdata[15:0], resp_lo[31:16]};
            2'd3:    resp_raw = {bank_rdata[23:0], resp_lo[31:24]};
            default: resp_raw = resp_lo;
        endcase
`else
        resp_raw = bank_rdata >> {cur_lane, 3'b000};
`endif
        resp_rdata = (cur_err || cur_we) ? 32'd0 : extend_load(cur_funct, resp_raw);
    end

    // Outputs show the live response during the valid cycle and the held one afterwards
    assign rdata_o = rvalid_o ? resp_rdata : rdata_hold;
    assign err_o   = rvalid_o ? cur_err    : err_hold;

    // Control FSM: accept in IDLE/RESP, optional second beat, one-cycle response
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            ready_o    <= 1'b1;
            rvalid_o   <= 1'b0;
            rdata_hold <= 32'd0;
            err_hold   <= 1'b0;
            cur_err    <= 1'b0;
            cur_we     <= 1'b0;
            cur_funct  <= 10'd0;
            cur_lane   <= 2'd0;
`ifdef DMEM_MISALIGN_EN
            cur_split    <= 1'b0;
            cur_idx      <= '0;
            cur_be_hi    <= 4'd0;
            cur_wdata_hi <= 32'd0;
            save_lo      <= 32'd0;
`endif
        end else begin
            if (rvalid_o) begin
                rdata_hold <= resp_rdata;
                err_hold   <= cur_err;
            end
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        cur_err   <= req_err;
                        cur_we    <= we_i;
                        cur_funct <= funct_i;
                        cur_lane  <= req_lane;
`ifdef DMEM_MISALIGN_EN
                        cur_split    <= req_split;
                        cur_idx      <= req_idx;
                        cur_be_hi    <= we_i ? be_hi : 4'd0;
                        cur_wdata_hi <= hi_wdata;
                        if (req_split) begin
                            state    <= ST_BEAT2;
                            ready_o  <= 1'b0;
                            rvalid_o <= 1'b0;
                        end else begin
                            state    <= ST_RESP;
                            ready_o  <= 1'b1;
                            rvalid_o <= 1'b1;
                        end
`else
                        state    <= ST_RESP;
                        ready_o  <= 1'b1;
                        rvalid_o <= 1'b1;
`endif
                    end else begin
                        state    <= ST_IDLE;
                        ready_o  <= 1'b1;
                        rvalid_o <= 1'b0;
                    end
                end
`ifdef DMEM_MISALIGN_EN
                ST_BEAT2: begin
                    save_lo  <= bank_rdata;
                    state    <= ST_RESP;
                    ready_o  <= 1'b1;
                    rvalid_o <= 1'b1;
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    ready_o  <= 1'b1;
                    rvalid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl with a small memory.
// Directed vector table, randomized accesses against a byte-array model,
// and hand-written back-to-back and reset-during-access sequences.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
`ifdef DMEM_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk_i;
    logic        rst_n_i;
    logic        req_i;
    logic        we_i;
    logic [9:0]  funct_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [4*DEPTH];

    typedef struct {
        logic        we;
        logic [9:0]  funct;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    dmem_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .req_i    (req_i),
        .we_i     (we_i),
        .funct_i  (funct_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [9:0] funct, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_lat);
        vec_t v;
        v.we = we; v.funct = funct; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Issue one request (called #1 after a rising edge) and collect its response
    task automatic applyStimulus(input logic we, input logic [9:0] funct, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rdata,
                                 output logic err, output int lat, output bit timed_out,
                                 output logic extra_pulse);
        int n;
        req_i = 1'b1; we_i = we; funct_i = funct; addr_i = addr; wdata_i = wdata;
        n = 0;
        while (!ready_o && n < 8) begin
            @(posedge clk_i); #1;
            n++;
        end
        @(posedge clk_i); #1;
        req_i = 1'b0;
        lat = 1;
        while (!rvalid_o && lat < 6) begin
            @(posedge clk_i); #1;
            lat++;
        end
        timed_out = !rvalid_o;
        rdata = rdata_o;
        err = err_o;
        @(posedge clk_i); #1;
        extra_pulse = rvalid_o;
    endtask

    task automatic runAccess(input string name, input logic we, input logic [9:0] funct,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          to;
        logic        extra;
        applyStimulus(we, funct, addr, wdata, rd, er, lat, to, extra);
        checkOutput({name, "_timeout"}, 32'(to), 32'd0);
        if (!to) begin
            checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
            checkOutput({name, "_err"}, 32'(er), 32'(exp_err));
            checkOutput({name, "_rdata"}, rd, exp_rdata);
            checkOutput({name, "_single_pulse"}, 32'(extra), 32'd0);
        end
    endtask

    // Reference behaviour from the access rules, on a flat byte array
    task automatic modelAccess(input logic we, input logic [9:0] funct, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] exp_rdata,
                               output logic exp_err, output int exp_lat);
        int          size;
        longint      a;
        longint      lim;
        longint      off;
        bit          in_range;
        bit          mis;
        logic [31:0] raw;
        case (funct)
            FUNC_LH, FUNC_LHU, FUNC_SH: size = 2;
            FUNC_LW, FUNC_SW:           size = 4;
            default:                    size = 1;
        endcase
        a = longint'(addr);
        lim = longint'(BASE) + 4 * DEPTH;
        in_range = (a >= longint'(BASE)) && (a + size <= lim);
        mis = (a % size) != 0;
        exp_err = !in_range || (mis && !MIS_EN);
        exp_rdata = 32'd0;
        raw = 32'd0;
        if (!exp_err) begin
            off = a - longint'(BASE);
            for (int i = 0; i < size; i++) begin
                if (we) model_mem[off + i] = wdata[8*i +: 8];
                else    raw[8*i +: 8] = model_mem[off + i];
            end
            if (!we) begin
                case (funct)
                    FUNC_LB:  exp_rdata = 32'(int'($signed(raw[7:0])));
                    FUNC_LH:  exp_rdata = 32'(int'($signed(raw[15:0])));
                    FUNC_LBU: exp_rdata = raw & 32'h0000_00FF;
                    FUNC_LHU: exp_rdata = raw & 32'h0000_FFFF;
                    default:  exp_rdata = raw;
                endcase
            end
        end
        exp_lat = (!exp_err && mis) ? 2 : 1;
    endtask

    initial begin
        logic [9:0]  fcodes [8];
        logic [31:0] er_d;
        logic        er_e;
        int          er_l;
        logic [31:0] w;
        logic [31:0] addr;
        logic [9:0]  f;
        logic        we;

        fcodes[0] = FUNC_LB; fcodes[1] = FUNC_LH; fcodes[2] = FUNC_LW; fcodes[3] = FUNC_LBU;
        fcodes[4] = FUNC_LHU; fcodes[5] = FUNC_SB; fcodes[6] = FUNC_SH; fcodes[7] = FUNC_SW;

        vecs.push_back(mk(1, FUNC_SW,  32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 0, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h8000_0000, 32'h0, 32'hDEAD_BEEF, 0, 1));
        vecs.push_back(mk(1, FUNC_SW,  32'h8000_0004, 32'h1122_3344, 32'h0, 0, 1));
        vecs.push_back(mk(1, FUNC_SB,  32'h8000_0005, 32'h0000_00A5, 32'h0, 0, 1));
        vecs.push_back(mk(0, FUNC_LB,  32'h8000_0005, 32'h0, 32'hFFFF_FFA5, 0, 1));
        vecs.push_back(mk(0, FUNC_LBU, 32'h8000_0005, 32'h0, 32'h0000_00A5, 0, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h8000_0004, 32'h0, 32'h1122_A544, 0, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h8000_0040, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h7FFF_FFFC, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(1, FUNC_SW,  32'h8000_0040, 32'h5555_5555, 32'h0, 1, 1));
        vecs.push_back(mk(1, FUNC_SW,  32'h8000_003C, 32'h0BAD_F00D, 32'h0, 0, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h8000_003C, 32'h0, 32'h0BAD_F00D, 0, 1));
        vecs.push_back(mk(0, FUNC_LH,  32'h8000_003F, 32'h0, 32'h0, 1, 1));
        vecs.push_back(mk(0, FUNC_LW,  32'h8000_0004, 32'h0, 32'h1122_A544, 0, 1));
        vecs.push_back(mk(1, FUNC_SW,  32'h8000_0008, 32'h4433_2211, 32'h0, 0, 1));
        vecs.push_back(mk(1, FUNC_SW,  32'h8000_000C, 32'h8877_6655, 32'h0, 0, 1));
        vecs.push_back(mk(0, FUNC_LH,  32'h8000_0006, 32'h0, 32'h0000_1122, 0, 1));
        vecs.push_back(mk(0, FUNC_LH,  32'h8000_000E, 32'h0, 32'hFFFF_8877, 0, 1));
        vecs.push_back(mk(0, FUNC_LHU, 32'h8000_000E, 32'h0, 32'h0000_8877, 0, 1));
        if (MIS_EN) begin
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_000A, 32'h0, 32'h6655_4433, 0, 2));
            vecs.push_back(mk(1, FUNC_SH, 32'h8000_0007, 32'h0000_BEEF, 32'h0, 0, 2));
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_0004, 32'h0, 32'hEF22_A544, 0, 1));
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_0008, 32'h0, 32'h4433_22BE, 0, 1));
            vecs.push_back(mk(0, FUNC_LH, 32'h8000_0001, 32'h0, 32'hFFFF_ADBE, 0, 2));
        end else begin
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_000A, 32'h0, 32'h0, 1, 1));
            vecs.push_back(mk(1, FUNC_SH, 32'h8000_0007, 32'h0000_BEEF, 32'h0, 1, 1));
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_0004, 32'h0, 32'h1122_A544, 0, 1));
            vecs.push_back(mk(0, FUNC_LW, 32'h8000_0008, 32'h0, 32'h4433_2211, 0, 1));
            vecs.push_back(mk(0, FUNC_LH, 32'h8000_0001, 32'h0, 32'h0, 1, 1));
        end

        rst_n_i = 1'b0; req_i = 1'b0; we_i = 1'b0; funct_i = FUNC_LW; addr_i = BASE; wdata_i = 32'd0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_ready", 32'(ready_o), 32'd1);
        checkOutput("reset_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("reset_rdata", rdata_o, 32'd0);
        checkOutput("reset_err", 32'(err_o), 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < vecs.size(); i++) begin
            runAccess($sformatf("vec%0d", i), vecs[i].we, vecs[i].funct, vecs[i].addr,
                      vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat);
        end

        $display("[TB] random accesses");
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            modelAccess(1'b1, FUNC_SW, BASE + 32'(4 * i), w, er_d, er_e, er_l);
            runAccess($sformatf("fill%0d", i), 1'b1, FUNC_SW, BASE + 32'(4 * i), w, er_d, er_e, er_l);
        end
        for (int i = 0; i < 300; i++) begin
            f = fcodes[$urandom_range(0, 7)];
            we = is_store_funct(f);
            if ($urandom_range(0, 9) == 0) begin
                addr = $urandom;
            end else begin
                addr = BASE + 32'($urandom_range(0, 4 * DEPTH + 7)) - 32'd4;
                if ($urandom_range(0, 1) == 0) addr = addr & ~32'(access_size(f) - 3'd1);
            end
            w = $urandom;
            modelAccess(we, f, addr, w, er_d, er_e, er_l);
            runAccess($sformatf("rand%0d", i), we, f, addr, w, er_d, er_e, er_l);
        end

        $display("[TB] back-to-back store then load");
        w = $urandom;
        modelAccess(1'b1, FUNC_SW, 32'h8000_0014, w, er_d, er_e, er_l);
        req_i = 1'b1; we_i = 1'b1; funct_i = FUNC_SW; addr_i = 32'h8000_0014; wdata_i = w;
        @(posedge clk_i); #1;
        checkOutput("b2b_sw_rvalid", 32'(rvalid_o), 32'd1);
        checkOutput("b2b_sw_err", 32'(err_o), 32'd0);
        checkOutput("b2b_sw_ready", 32'(ready_o), 32'd1);
        we_i = 1'b0; funct_i = FUNC_LW;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        checkOutput("b2b_lw_rvalid", 32'(rvalid_o), 32'd1);
        checkOutput("b2b_lw_rdata", rdata_o, w);
        checkOutput("b2b_lw_err", 32'(err_o), 32'd0);
        @(posedge clk_i); #1;
        checkOutput("b2b_idle_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("b2b_hold_rdata", rdata_o, w);

        $display("[TB] reset at accept edge");
        req_i = 1'b1; we_i = 1'b1; funct_i = FUNC_SW; addr_i = 32'h8000_0018; wdata_i = ~w;
        rst_n_i = 1'b0;
        @(posedge clk_i); #1;
        checkOutput("rst_accept_rvalid", 32'(rvalid_o), 32'd0);
        checkOutput("rst_accept_ready", 32'(ready_o), 32'd1);
        rst_n_i = 1'b1; req_i = 1'b0;
        @(posedge clk_i); #1;
        modelAccess(1'b0, FUNC_LW, 32'h8000_0018, 32'd0, er_d, er_e, er_l);
        runAccess("rst_accept_nowrite", 1'b0, FUNC_LW, 32'h8000_0018, 32'd0, er_d, er_e, er_l);

        if (MIS_EN) begin
            $display("[TB] reset during second beat of a split store");
            modelAccess(1'b1, FUNC_SW, 32'h8000_0010, 32'd0, er_d, er_e, er_l);
            runAccess("beat2_clr0", 1'b1, FUNC_SW, 32'h8000_0010, 32'd0, er_d, er_e, er_l);
            modelAccess(1'b1, FUNC_SW, 32'h8000_0014, 32'd0, er_d, er_e, er_l);
            runAccess("beat2_clr1", 1'b1, FUNC_SW, 32'h8000_0014, 32'd0, er_d, er_e, er_l);
            req_i = 1'b1; we_i = 1'b1; funct_i = FUNC_SW; addr_i = 32'h8000_0012; wdata_i = 32'hCAFE_F00D;
            @(posedge clk_i); #1;
            checkOutput("beat2_ready_low", 32'(ready_o), 32'd0);
            rst_n_i = 1'b0; req_i = 1'b0;
            @(posedge clk_i); #1;
            checkOutput("beat2_rst_rvalid", 32'(rvalid_o), 32'd0);
            checkOutput("beat2_rst_ready", 32'(ready_o), 32'd1);
            rst_n_i = 1'b1;
            @(posedge clk_i); #1;
            checkOutput("beat2_after_rvalid", 32'(rvalid_o), 32'd0);
            model_mem[32'h12] = 8'h0D;
            model_mem[32'h13] = 8'hF0;
            modelAccess(1'b0, FUNC_LW, 32'h8000_0014, 32'd0, er_d, er_e, er_l);
            runAccess("beat2_next_word", 1'b0, FUNC_LW, 32'h8000_0014, 32'd0, er_d, er_e, er_l);
            modelAccess(1'b0, FUNC_LW, 32'h8000_0010, 32'd0, er_d, er_e, er_l);
            runAccess("beat2_first_word", 1'b0, FUNC_LW, 32'h8000_0010, 32'd0, er_d, er_e, er_l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
